store_write_buffer: RTL and testbench

//  Posted-store FIFO between the EX/MEM stage and the data memory write port.
//  - Stores are accepted in one cycle and drained to memory in order, one per free memory cycle.
//  - Loads look up pending stores and receive forwarded data on an address match.
//  - o_empty acts as the fence / drain-complete signal for the pipeline.

---
 rtl/store_write_buffer.sv | 150 +++++++++++++++
 tb/tb_store_write_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_write_buffer
// Description : Posted-store FIFO between the EX/MEM stage and the data memory
//               write port. Stores are accepted in one cycle and drained in
//               order, one per cycle in which the memory port is free. Loads
//               look up pending stores and receive the youngest matching data.
//               o_empty doubles as the fence / drain-complete indication.
//
// Ports       : i_clk, i_rst                clock, synchronous active-high reset
//               i_st_valid/addr/data        store request
//               o_st_ready                  store can be accepted this cycle
//               i_ld_valid/addr             load lookup
//               o_fwd_hit/o_fwd_data        forwarding result
//               i_mem_busy                  memory port taken by a load
//               o_mem_we/addr/wdata         write port toward data memory
//               o_count/o_empty             occupancy
//
// Options     : WBUF_COALESCE_EN - a store to the address of the youngest
//               pending entry overwrites that entry in place (also when full).
//
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_st_valid,
    input  logic [ADDR_W-1:0]          i_st_addr,
    input  logic [DATA_W-1:0]          i_st_data,
    output logic                       o_st_ready,
    input  logic                       i_ld_valid,
    input  logic [ADDR_W-1:0]          i_ld_addr,
    output logic                       o_fwd_hit,
    output logic [DATA_W-1:0]          o_fwd_data,
    input  logic                       i_mem_busy,
    output logic                       o_mem_we,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [DATA_W-1:0]          o_mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [PTR_W-1:0]  youngest;
    logic              full;
    logic              not_empty;
    logic              pop;
    logic              coalesce_match;
    logic              enq;
    logic              alloc;

    assign youngest  = wr_ptr - PTR_W'(1);
    assign full      = (count == CNT_W'(DEPTH));
    assign not_empty = (count != '0);

    // Head leaves the buffer at the same edge the memory samples the write.
    assign pop       = not_empty && !i_mem_busy && !i_rst;

`ifdef WBUF_COALESCE_EN
    // The youngest entry is the head only when count == 1; if that head is
    // being written this cycle it cannot be modified, so the store allocates.
    assign coalesce_match = not_empty
                         && (addr_mem[youngest] == i_st_addr)
                         && !((count == CNT_W'(1)) && pop);
    assign o_st_ready     = !full || coalesce_match;
`else
    assign coalesce_match = 1'b0;
    assign o_st_ready     = !full;
`endif

    assign enq   = i_st_valid && o_st_ready;
    assign alloc = enq && !coalesce_match;

    assign o_mem_we    = pop;
    assign o_mem_addr  = addr_mem[rd_ptr];
    assign o_mem_wdata = data_mem[rd_ptr];
    assign o_count     = count;
    assign o_empty     = !not_empty;

    // Forwarding: walk occupied entries oldest to youngest so the last match
    // found is the youngest one.
    logic [PTR_W-1:0]  fwd_idx;
    logic              fwd_hit_raw;
    logic [DATA_W-1:0] fwd_data_raw;

    always_comb begin
        fwd_idx      = '0;
        fwd_hit_raw  = 1'b0;
        fwd_data_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[fwd_idx] == i_ld_addr)) begin
                fwd_hit_raw  = 1'b1;
                fwd_data_raw = data_mem[fwd_idx];
            end
        end
    end

    assign o_fwd_hit  = fwd_hit_raw && i_ld_valid && !i_rst;
    assign o_fwd_data = fwd_data_raw;

    // Control state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (alloc && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!alloc && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (alloc) begin
                addr_mem[wr_ptr] <= i_st_addr;
                data_mem[wr_ptr] <= i_st_data;
            end else if (enq) begin
                data_mem[youngest] <= i_st_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_store_write_buffer
// Description : Self-checking bench for store_write_buffer. A queue model of
//               the pending stores is the scoreboard: accepted stores are
//               pushed, memory writes pop and compare against the head.
//               Honors WBUF_COALESCE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        count;
    logic              empty;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t q[$];

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_st_valid  (st_valid),
        .i_st_addr   (st_addr),
        .i_st_data   (st_data),
        .o_st_ready  (st_ready),
        .i_ld_valid  (ld_valid),
        .i_ld_addr   (ld_addr),
        .o_fwd_hit   (fwd_hit),
        .o_fwd_data  (fwd_data),
        .i_mem_busy  (mem_busy),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_count     (count),
        .o_empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_we();
        return (q.size() != 0) && !mem_busy && !rst;
    endfunction

    function automatic bit m_coal();
`ifdef WBUF_COALESCE_EN
        return (q.size() != 0) && (q[q.size()-1].addr == st_addr)
            && !((q.size() == 1) && m_we());
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        return (q.size() != DEPTH) || m_coal();
    endfunction

    always @(posedge clk) begin
        bit we, acc, co;
        entry_t e;
        we  = m_we();
        acc = st_valid && m_ready();
        co  = m_coal();
        if (rst) begin
            q.delete();
        end else begin
            if (acc && co) q[q.size()-1].data = st_data;
            if (we) void'(q.pop_front());
            if (acc && !co) begin
                e.addr = st_addr;
                e.data = st_data;
                q.push_back(e);
            end
        end
    end

    // Monitor: outputs versus the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit            h;
        logic [DATA_W-1:0] d;
        if (mon_en) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            chk("st_ready", 64'(st_ready), 64'(m_ready()));
            chk("mem_we", 64'(mem_we), 64'(m_we()));
            if (m_we()) begin
                chk("wr_addr", 64'(mem_addr), 64'(q[0].addr));
                chk("wr_data", 64'(mem_wdata), 64'(q[0].data));
            end
            h = 1'b0;
            d = '0;
            if (ld_valid && !rst) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!h && q[i].addr == ld_addr) begin
                        h = 1'b1;
                        d = q[i].data;
                    end
                end
            end
            chk("fwd_hit", 64'(fwd_hit), 64'(h));
            if (h) chk("fwd_data", 64'(fwd_data), 64'(d));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_busy = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(st_ready), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        step();

        // 1: reset while draining
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) store(32'(100 + k), 32'(32'h100 + k));
        mem_busy = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_we_forced", 64'(mem_we), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        repeat (3) step();

        // 2: order, full, wrap
        mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) store(32'(4 * (k + 1)), 32'(32'hA0 + k));
        st_addr = 32'd16;
        @(negedge clk);
`ifdef WBUF_COALESCE_EN
        chk("full_coal_ready", 64'(st_ready), 64'd1);
`else
        chk("full_ready", 64'(st_ready), 64'd0);
`endif
        step();
        st_valid = 1'b1; st_addr = 32'd20; st_data = 32'hA4;
        @(negedge clk);
        chk("full_ready_hold", 64'(st_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        step();
        mem_busy = 1'b0;
        step();
        step();
        st_valid = 1'b0;
        repeat (5) step();
        for (int k = 0; k < 5; k++) store(32'(24 + 4 * k), 32'(32'hB0 + k));
        repeat (3) step();
        @(negedge clk);
        chk("wrap_empty", 64'(empty), 64'd1);
        step();

        // 3: simultaneous enqueue and drain
        mem_busy = 1'b1;
        store(32'd50, 32'h50);
        store(32'd51, 32'h51);
        mem_busy = 1'b0;
        st_valid = 1'b1; st_addr = 32'd52; st_data = 32'h52;
        @(negedge clk);
        chk("simul_we", 64'(mem_we), 64'd1);
        chk("simul_addr", 64'(mem_addr), 64'd50);
        step();
        st_valid = 1'b0;
        mem_busy = 1'b1;
        @(negedge clk);
        chk("simul_count", 64'(count), 64'd2);
        chk("simul_head", 64'(mem_addr), 64'd51);
        step();
        mem_busy = 1'b0;
        repeat (3) step();

        // 4: forwarding
        mem_busy = 1'b1;
        store(32'd8, 32'h11);
        store(32'd8, 32'h22);
        ld_valid = 1'b1; ld_addr = 32'd8;
        @(negedge clk);
        chk("fwd8_hit", 64'(fwd_hit), 64'd1);
        chk("fwd8_data", 64'(fwd_data), 64'h22);
        step();
        ld_addr = 32'd12;
        @(negedge clk);
        chk("fwd12_miss", 64'(fwd_hit), 64'd0);
        step();
        st_valid = 1'b1; st_addr = 32'd12; st_data = 32'h33;
        @(negedge clk);
        chk("fwd_same_cycle", 64'(fwd_hit), 64'd0);
        step();
        st_valid = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        chk("fwd_ld_invalid", 64'(fwd_hit), 64'd0);
        step();
        mem_busy = 1'b0;
        repeat (4) step();

        // 5: busy stall
        mem_busy = 1'b1;
        store(32'd60, 32'h5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_we", 64'(mem_we), 64'd0);
            chk("stall_head", 64'(mem_addr), 64'd60);
            step();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        chk("stall_release_we", 64'(mem_we), 64'd1);
        chk("stall_release_data", 64'(mem_wdata), 64'h5);
        step();
        @(negedge clk);
        chk("stall_done", 64'(count), 64'd0);
        step();

        // 6: same-address stores (coalescing when enabled)
        mem_busy = 1'b1;
        store(32'd20, 32'h1);
        store(32'd20, 32'h2);
        @(negedge clk);
`ifdef WBUF_COALESCE_EN
        chk("coal_count", 64'(count), 64'd1);
`else
        chk("nocoal_count", 64'(count), 64'd2);
`endif
        step();
        mem_busy = 1'b0;
        repeat (3) step();
        // head being written is never modified in place
        store(32'd70, 32'h7);
        st_valid = 1'b1; st_addr = 32'd70; st_data = 32'h8;
        @(negedge clk);
        chk("head_drain_we", 64'(mem_we), 64'd1);
        chk("head_drain_data", 64'(mem_wdata), 64'h7);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("head_drain_count", 64'(count), 64'd1);
        chk("head_drain_new", 64'(mem_wdata), 64'h8);
        repeat (3) step();
        @(negedge clk);
        chk("final_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
